predecode_ir: RTL and testbench

Instruction register and interrupt injector for the cpu6502 core; sits directly downstream of the timing control unit. On every enabled clock edge where the TCU's sync output is high, it latches the fetched opcode from the data bus, or forces BRK (0x00) when a reset, NMI or IRQ sequence must run. It also synchronises and edge-detects the interrupt pins, so the decoder sees one stable opcode plus an interrupt-type tag for the whole instruction.

---
 rtl/cpu6502_pkg.sv | 20 ++
 rtl/predecode_ir_sync2.sv | 33 +++
 rtl/predecode_ir.sv | 123 ++++++++++++
 tb/tb_predecode_ir.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// ---------------------------------------------------------------------------
// cpu6502_pkg
// Shared constants for the cpu6502 core.
//   int_type_e  : tag carried alongside the instruction register that says
//                 whether the current opcode is a real fetch or an injected
//                 BRK, and if injected, which sequence it serves.
//   OPCODE_BRK  : opcode forced into the IR for reset/NMI/IRQ sequences.
// ---------------------------------------------------------------------------
package cpu6502_pkg;

   typedef enum logic [1:0] {
      INT_NONE  = 2'd0,
      INT_RESET = 2'd1,
      INT_NMI   = 2'd2,
      INT_IRQ   = 2'd3
   } int_type_e;

   localparam logic [7:0] OPCODE_BRK = 8'h00;

endpackage

// File: rtl/predecode_ir_sync2.sv
// ---------------------------------------------------------------------------
// predecode_ir_sync2
// Two-flop synchroniser for an asynchronous, active-low CPU input pin.
// Clocked on the falling edge, like the rest of the CPU. It only advances on
// enabled cycles. Reset drives both flops to 1, which is the idle pin level.
//   i_clk      : CPU clock (falling edge active)
//   i_reset_n  : asynchronous active-low reset, sets the chain to 1
//   i_clk_en   : clock enable; the chain holds when low
//   i_d        : raw asynchronous pin
//   o_q        : synchronised pin (second flop)
// ---------------------------------------------------------------------------
module predecode_ir_sync2 (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clk_en,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] chain_q;

   // Shift the pin through two flops; bit 0 is the metastability catcher.
   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         chain_q <= 2'b11;
      end else if (i_clk_en) begin
         chain_q <= {chain_q[0], i_d};
      end
   end

   assign o_q = chain_q[1];

endmodule

// File: rtl/predecode_ir.sv
// ---------------------------------------------------------------------------
// predecode_ir
// Instruction register and interrupt injector for the cpu6502 core.
// On an enabled sync cycle it latches the fetched opcode, or forces BRK when a
// reset, NMI or IRQ sequence has to run. It tags the instruction with the
// interrupt type so the decoder sees one stable opcode and tag per instruction.
//   i_clk            : CPU clock, state updates on the falling edge
//   i_reset_n        : asynchronous active-low reset
//   i_clk_en         : clock enable; all state holds when low
//   i_sync           : opcode fetch cycle from the TCU
//   i_data[7:0]      : data bus (opcode during sync)
//   i_nmi_n          : NMI pin, falling-edge triggered
//   i_irq_n          : IRQ pin, level, active-low
//   i_irq_mask       : processor I flag; 1 masks IRQ
//   o_ir[7:0]        : current instruction opcode
//   o_int_type[1:0]  : NONE / RESET / NMI / IRQ tag of the current instruction
//   o_pc_inc_inhibit : PC must not advance past the fetched byte
//   o_nmi_pending    : NMI edge seen but not yet injected
//   o_irq_request    : synchronised IRQ asserted and unmasked
// ---------------------------------------------------------------------------
module predecode_ir
   import cpu6502_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_clk_en,
   input  logic       i_sync,
   input  logic [7:0] i_data,
   input  logic       i_nmi_n,
   input  logic       i_irq_n,
   input  logic       i_irq_mask,
   output logic [7:0] o_ir,
   output logic [1:0] o_int_type,
   output logic       o_pc_inc_inhibit,
   output logic       o_nmi_pending,
   output logic       o_irq_request
);

   logic      nmiS2;
   logic      irqS2;
   logic      nmiPrev_q;
   logic      nmiEdge;
   logic      irqRequest;

   logic [7:0] ir_q,            ir_d;
   int_type_e  intType_q,       intType_d;
   logic       resetPending_q,  resetPending_d;
   logic       nmiPending_q,    nmiPending_d;

   predecode_ir_sync2 u_nmiSync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clk_en  (i_clk_en),
      .i_d       (i_nmi_n),
      .o_q       (nmiS2)
   );

   predecode_ir_sync2 u_irqSync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clk_en  (i_clk_en),
      .i_d       (i_irq_n),
      .o_q       (irqS2)
   );

   // A falling NMI is the synchronised level being low while the level one
   // enabled cycle earlier was high. IRQ is level-sensitive and not latched.
   assign nmiEdge    = !nmiS2 && nmiPrev_q;
   assign irqRequest = !irqS2 && !i_irq_mask;

   // Next-state for the IR, its tag and the pending flags. A new NMI edge
   // arriving on the same cycle that injects the previous NMI keeps the flag
   // set, so the second NMI is taken at the following sync.
   always_comb begin
      ir_d           = ir_q;
      intType_d      = intType_q;
      resetPending_d = resetPending_q;
      nmiPending_d   = nmiPending_q || nmiEdge;

      if (i_sync) begin
         resetPending_d = 1'b0;
         if (resetPending_q) begin
            ir_d      = OPCODE_BRK;
            intType_d = INT_RESET;
         end else if (nmiPending_q) begin
            ir_d         = OPCODE_BRK;
            intType_d    = INT_NMI;
            nmiPending_d = nmiEdge;
         end else if (irqRequest) begin
            ir_d      = OPCODE_BRK;
            intType_d = INT_IRQ;
         end else begin
            ir_d      = i_data;
            intType_d = INT_NONE;
         end
      end
   end

   // State registers. Reset puts the core into the reset sequence and drops
   // any pending NMI; a low clock enable freezes everything.
   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ir_q           <= OPCODE_BRK;
         intType_q      <= INT_RESET;
         resetPending_q <= 1'b1;
         nmiPending_q   <= 1'b0;
         nmiPrev_q      <= 1'b1;
      end else if (i_clk_en) begin
         ir_q           <= ir_d;
         intType_q      <= intType_d;
         resetPending_q <= resetPending_d;
         nmiPending_q   <= nmiPending_d;
         nmiPrev_q      <= nmiS2;
      end
   end

   assign o_ir             = ir_q;
   assign o_int_type       = intType_q;
   assign o_pc_inc_inhibit = (intType_q != INT_NONE);
   assign o_nmi_pending    = nmiPending_q;
   assign o_irq_request    = irqRequest;

endmodule

// File: tb/tb_predecode_ir.sv
// ---------------------------------------------------------------------------
// tb_predecode_ir
// Directed bench for predecode_ir. Inputs change on the rising clock edge and
// outputs are checked on the rising edge after the active falling edge.
// ---------------------------------------------------------------------------
module tb_predecode_ir;

   logic       i_clk;
   logic       i_reset_n;
   logic       i_clk_en;
   logic       i_sync;
   logic [7:0] i_data;
   logic       i_nmi_n;
   logic       i_irq_n;
   logic       i_irq_mask;
   logic [7:0] o_ir;
   logic [1:0] o_int_type;
   logic       o_pc_inc_inhibit;
   logic       o_nmi_pending;
   logic       o_irq_request;

   int vectors;
   int miscompares;

   predecode_ir dut (
      .i_clk            (i_clk),
      .i_reset_n        (i_reset_n),
      .i_clk_en         (i_clk_en),
      .i_sync           (i_sync),
      .i_data           (i_data),
      .i_nmi_n          (i_nmi_n),
      .i_irq_n          (i_irq_n),
      .i_irq_mask       (i_irq_mask),
      .o_ir             (o_ir),
      .o_int_type       (o_int_type),
      .o_pc_inc_inhibit (o_pc_inc_inhibit),
      .o_nmi_pending    (o_nmi_pending),
      .o_irq_request    (o_irq_request)
   );

   // Free-running clock; the DUT acts on the falling edge.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Drive the DUT inputs for the next active edge.
   task automatic applyStimulus(input logic en, input logic sync, input logic [7:0] data,
                                input logic nmiN, input logic irqN, input logic mask);
      i_clk_en   = en;
      i_sync     = sync;
      i_data     = data;
      i_nmi_n    = nmiN;
      i_irq_n    = irqN;
      i_irq_mask = mask;
   endtask

   // Let one falling (active) edge pass and return on the following rising edge.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge i_clk);
         @(posedge i_clk);
      end
   endtask

   // One comparison: count it, and on a miscompare count and report it.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%02h, expected 0x%02h", tag, observed, expected);
      end
   endtask

   // Check the IR, tag and inhibit together.
   task automatic checkIr(input string tag, input logic [7:0] ir, input logic [1:0] typ);
      checkOutput({tag, ".ir"}, o_ir, ir);
      checkOutput({tag, ".type"}, {6'd0, o_int_type}, {6'd0, typ});
      checkOutput({tag, ".inhibit"}, {7'd0, o_pc_inc_inhibit}, {7'd0, (typ != 2'd0)});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      i_reset_n   = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      tick(3);

      // Reset state
      checkIr("reset", 8'h00, 2'd1);
      checkOutput("reset.nmiPending", {7'd0, o_nmi_pending}, 8'd0);
      checkOutput("reset.irqRequest", {7'd0, o_irq_request}, 8'd0);
      i_reset_n = 1'b1;

      // First sync after reset injects the reset BRK, the next one loads the opcode
      applyStimulus(1'b1, 1'b1, 8'hA9, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkIr("sync1", 8'h00, 2'd1);
      tick(1);
      checkIr("sync2", 8'hA9, 2'd0);

      // NMI falling edge: pending exactly after the third enabled edge
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      tick(1);
      checkOutput("nmiE1", {7'd0, o_nmi_pending}, 8'd0);
      tick(1);
      checkOutput("nmiE2", {7'd0, o_nmi_pending}, 8'd0);
      tick(1);
      checkOutput("nmiE3", {7'd0, o_nmi_pending}, 8'd1);
      checkIr("nmiHold", 8'hA9, 2'd0);
      applyStimulus(1'b1, 1'b1, 8'hEA, 1'b0, 1'b1, 1'b1);
      tick(1);
      checkIr("nmiInject", 8'h00, 2'd2);
      checkOutput("nmiCleared", {7'd0, o_nmi_pending}, 8'd0);
      tick(1);
      checkIr("nmiNoRetrigger", 8'hEA, 2'd0);
      checkOutput("nmiStillClear", {7'd0, o_nmi_pending}, 8'd0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      tick(3);

      // Masked IRQ is ignored, unmasking injects it
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      tick(2);
      checkOutput("irqMasked", {7'd0, o_irq_request}, 8'd0);
      applyStimulus(1'b1, 1'b1, 8'h4C, 1'b1, 1'b0, 1'b1);
      tick(1);
      checkIr("irqMaskedLoad", 8'h4C, 2'd0);
      applyStimulus(1'b1, 1'b1, 8'h60, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("irqUnmasked", {7'd0, o_irq_request}, 8'd1);
      tick(1);
      checkIr("irqInject", 8'h00, 2'd3);
      applyStimulus(1'b1, 1'b1, 8'h60, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkIr("irqLost", 8'h60, 2'd0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      tick(2);

      // NMI and IRQ at the same sync: NMI first, IRQ on the next sync
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick(3);
      checkOutput("bothNmiPending", {7'd0, o_nmi_pending}, 8'd1);
      checkOutput("bothIrqRequest", {7'd0, o_irq_request}, 8'd1);
      applyStimulus(1'b1, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkIr("bothFirst", 8'h00, 2'd2);
      tick(1);
      checkIr("bothSecond", 8'h00, 2'd3);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      tick(3);
      applyStimulus(1'b1, 1'b1, 8'h8D, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkIr("preFreeze", 8'h8D, 2'd0);

      // Clock enable low: nothing moves despite sync, data and pin activity
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
         tick(1);
      end
      checkIr("freeze", 8'h8D, 2'd0);
      checkOutput("freezeNmi", {7'd0, o_nmi_pending}, 8'd0);
      checkOutput("freezeIrq", {7'd0, o_irq_request}, 8'd0);

      // Re-enable: NMI edge detection restarts from the first enabled edge
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      tick(2);
      checkOutput("resumeE2", {7'd0, o_nmi_pending}, 8'd0);
      tick(1);
      checkOutput("resumeE3", {7'd0, o_nmi_pending}, 8'd1);

      // Asynchronous reset mid-instruction discards the pending NMI
      #1;
      i_reset_n = 1'b0;
      #1;
      checkIr("asyncReset", 8'h00, 2'd1);
      checkOutput("asyncResetNmi", {7'd0, o_nmi_pending}, 8'd0);
      @(posedge i_clk);
      i_reset_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkIr("postReset1", 8'h00, 2'd1);
      tick(1);
      checkIr("postReset2", 8'hA2, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
